// File: rtl/cv32e40p_localparam_pkg.sv
// Shared constants and types for the hardware-loop bank.
package cv32e40p_localparam_pkg;

  localparam int unsigned HWLP_N_DEFAULT = 2;
  localparam int unsigned HWLP_ADDR_W    = 32;
  localparam int unsigned HWLP_CNT_W     = 32;

  // Bit positions inside hwlp_we_i
  localparam int unsigned HWLP_WE_START = 0;
  localparam int unsigned HWLP_WE_END   = 1;
  localparam int unsigned HWLP_WE_CNT   = 2;

  typedef struct packed {
    logic [HWLP_ADDR_W-1:0] start_addr;
    logic [HWLP_ADDR_W-1:0] end_addr;
    logic [HWLP_CNT_W-1:0]  cnt;
  } hwlp_ctx_t;

  // Register-id width; a single loop still needs one id bit
  function automatic int unsigned hwlp_regid_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cv32e40p_hwlp_entry.sv
// One hardware-loop context: start/end/count registers, end-of-loop match
// and the write-over-decrement priority for the counter.
module cv32e40p_hwlp_entry
  import cv32e40p_localparam_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        we_i,
  input  logic [ADDR_W-1:0] start_data_i,
  input  logic [ADDR_W-1:0] end_data_i,
  input  logic [CNT_W-1:0]  cnt_data_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              dec_i,
  output logic [ADDR_W-1:0] start_o,
  output logic [ADDR_W-1:0] end_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              match_o
);

  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next state: a count write overrides a same-cycle decrement
  always_comb begin
    start_d = we_i[HWLP_WE_START] ? start_data_i : start_q;
    end_d   = we_i[HWLP_WE_END]   ? end_data_i   : end_q;
    cnt_d   = cnt_q;
    if (we_i[HWLP_WE_CNT]) begin
      cnt_d = cnt_data_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

  // A zero count marks the loop inactive
  always_comb begin
    start_o = start_q;
    end_o   = end_q;
    cnt_o   = cnt_q;
    match_o = (pc_i == end_q) && (cnt_q != '0);
  end

endmodule

// File: rtl/cv32e40p_hwlp_bank.sv
// Hardware-loop register bank and loop-end controller.
// Optional macro CV32E40P_HWLP_NEST_CHECK_EN adds hwlp_nest_err_o, flagging
// a count write that leaves an outer loop ending before an active inner one.
module cv32e40p_hwlp_bank
  import cv32e40p_localparam_pkg::*;
#(
  parameter int unsigned N_HWLP      = HWLP_N_DEFAULT,
  parameter int unsigned N_HWLP_BITS = hwlp_regid_bits(N_HWLP),
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_HWLP_BITS-1:0]   hwlp_regid_i,
  input  logic [2:0]               hwlp_we_i,
  input  logic [ADDR_W-1:0]        hwlp_start_data_i,
  input  logic [ADDR_W-1:0]        hwlp_end_data_i,
  input  logic [CNT_W-1:0]         hwlp_cnt_data_i,
  input  logic [ADDR_W-1:0]        pc_id_i,
  input  logic                     id_valid_i,
  output logic [N_HWLP*ADDR_W-1:0] hwlp_start_o,
  output logic [N_HWLP*ADDR_W-1:0] hwlp_end_o,
  output logic [N_HWLP*CNT_W-1:0]  hwlp_cnt_o,
  output logic                     hwlp_jump_o,
  output logic [ADDR_W-1:0]        hwlp_target_o,
`ifdef CV32E40P_HWLP_NEST_CHECK_EN
  output logic                     hwlp_nest_err_o,
`endif
  output logic [N_HWLP-1:0]        hwlp_dec_o
);

  logic [ADDR_W-1:0] start_q [N_HWLP];
  logic [ADDR_W-1:0] end_q   [N_HWLP];
  logic [CNT_W-1:0]  cnt_q   [N_HWLP];
  logic [N_HWLP-1:0] match;
  logic [N_HWLP-1:0] regid_hit;
  logic [N_HWLP-1:0] sel_onehot;
  logic              sel_found;
  logic [ADDR_W-1:0] sel_start;
  logic [CNT_W-1:0]  sel_cnt;

  for (genvar i = 0; i < N_HWLP; i++) begin : g_entry
    // Out-of-range regids hit no entry, so such writes vanish
    assign regid_hit[i] = (hwlp_regid_i == N_HWLP_BITS'(i));

    cv32e40p_hwlp_entry #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .we_i         (regid_hit[i] ? hwlp_we_i : 3'b000),
      .start_data_i (hwlp_start_data_i),
      .end_data_i   (hwlp_end_data_i),
      .cnt_data_i   (hwlp_cnt_data_i),
      .pc_i         (pc_id_i),
      .dec_i        (id_valid_i && sel_onehot[i]),
      .start_o      (start_q[i]),
      .end_o        (end_q[i]),
      .cnt_o        (cnt_q[i]),
      .match_o      (match[i])
    );

    assign hwlp_start_o[i*ADDR_W +: ADDR_W] = start_q[i];
    assign hwlp_end_o[i*ADDR_W +: ADDR_W]   = end_q[i];
    assign hwlp_cnt_o[i*CNT_W +: CNT_W]     = cnt_q[i];
  end

  // Priority encoder: lowest-index match is the innermost loop and wins
  always_comb begin
    sel_found  = 1'b0;
    sel_onehot = '0;
    sel_start  = '0;
    sel_cnt    = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      if (!sel_found && match[i]) begin
        sel_found     = 1'b1;
        sel_onehot[i] = 1'b1;
        sel_start     = start_q[i];
        sel_cnt       = cnt_q[i];
      end
    end
  end

  // Jump only while iterations remain; the last pass falls through
  always_comb begin
    hwlp_dec_o    = id_valid_i ? sel_onehot : '0;
    hwlp_jump_o   = id_valid_i && sel_found && (sel_cnt > CNT_W'(1));
    hwlp_target_o = hwlp_jump_o ? sel_start : '0;
  end

`ifdef CV32E40P_HWLP_NEST_CHECK_EN
  logic nest_err_q, nest_err_d;
  logic nest_viol;
  logic cnt_wr;

  // Violation: some active lower-index loop ends past the written loop's end
  always_comb begin
    nest_viol = 1'b0;
    cnt_wr    = hwlp_we_i[HWLP_WE_CNT] && (|regid_hit);
    for (int j = 1; j < N_HWLP; j++) begin
      if (regid_hit[j]) begin
        for (int i = 0; i < j; i++) begin
          if ((cnt_q[i] != '0) &&
              (end_q[i] > (hwlp_we_i[HWLP_WE_END] ? hwlp_end_data_i : end_q[j]))) begin
            nest_viol = 1'b1;
          end
        end
      end
    end
    nest_err_d = cnt_wr ? nest_viol : nest_err_q;
  end

  // Nesting error flag, re-evaluated on every count write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nest_err_q <= 1'b0;
    end else begin
      nest_err_q <= nest_err_d;
    end
  end

  assign hwlp_nest_err_o = nest_err_q;
`endif

endmodule

// File: tb/tb_cv32e40p_hwlp_bank.sv
// Self-checking bench for cv32e40p_hwlp_bank with four loop contexts.
module tb_cv32e40p_hwlp_bank;

  localparam int unsigned N  = 4;
  localparam int unsigned NB = 3;  // wide enough to address an out-of-range regid

  logic            clk;
  logic            rst_n;
  logic [NB-1:0]   regid;
  logic [2:0]      we;
  logic [31:0]     start_data, end_data, cnt_data;
  logic [31:0]     pc;
  logic            valid;
  logic [N*32-1:0] start_o, end_o, cnt_o;
  logic            jump;
  logic [31:0]     target;
  logic [N-1:0]    dec;
`ifdef CV32E40P_HWLP_NEST_CHECK_EN
  logic            nest_err;
`endif

  typedef struct {
    logic        jump;
    logic [31:0] target;
    logic [3:0]  dec;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  cv32e40p_hwlp_bank #(
    .N_HWLP      (N),
    .N_HWLP_BITS (NB),
    .ADDR_W      (32),
    .CNT_W       (32)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .hwlp_regid_i      (regid),
    .hwlp_we_i         (we),
    .hwlp_start_data_i (start_data),
    .hwlp_end_data_i   (end_data),
    .hwlp_cnt_data_i   (cnt_data),
    .pc_id_i           (pc),
    .id_valid_i        (valid),
    .hwlp_start_o      (start_o),
    .hwlp_end_o        (end_o),
    .hwlp_cnt_o        (cnt_o),
    .hwlp_jump_o       (jump),
    .hwlp_target_o     (target),
`ifdef CV32E40P_HWLP_NEST_CHECK_EN
    .hwlp_nest_err_o   (nest_err),
`endif
    .hwlp_dec_o        (dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [NB-1:0] id, input logic [2:0] w,
                    input logic [31:0] s, input logic [31:0] en, input logic [31:0] c);
    @(negedge clk);
    regid = id; we = w; start_data = s; end_data = en; cnt_data = c;
    @(posedge clk);
    #1 we = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; regid = '0; we = '0; start_data = '0; end_data = '0; cnt_data = '0;
    pc = '0; valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (start_o !== '0) begin errors++; $display("FAIL reset_start: got %h want 0", start_o); end
    checks++; if (end_o !== '0) begin errors++; $display("FAIL reset_end: got %h want 0", end_o); end
    checks++; if (cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %h want 0", cnt_o); end
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL reset_jump: got %b want 0", jump); end
    checks++; if (target !== '0) begin errors++; $display("FAIL reset_target: got %h want 0", target); end
    checks++; if (dec !== '0) begin errors++; $display("FAIL reset_dec: got %b want 0", dec); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_loop();
    logic [31:0] cnt_exp [4];
    cnt_exp = '{32'd2, 32'd1, 32'd0, 32'd0};
    wr(3'd0, 3'b111, 32'h100, 32'h110, 32'd3);
    exp_q.push_back('{1'b1, 32'h100, 4'b0001});
    exp_q.push_back('{1'b1, 32'h100, 4'b0001});
    exp_q.push_back('{1'b0, 32'h0,   4'b0001});
    exp_q.push_back('{1'b0, 32'h0,   4'b0000});  // counter exhausted: inactive
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pc = 32'h110; valid = 1'b1;
      #1 e = exp_q.pop_front();
      checks++; if (jump !== e.jump) begin errors++; $display("FAIL basic_jump[%0d]: got %b want %b", k, jump, e.jump); end
      checks++; if (target !== e.target) begin errors++; $display("FAIL basic_target[%0d]: got %h want %h", k, target, e.target); end
      checks++; if (dec !== e.dec) begin errors++; $display("FAIL basic_dec[%0d]: got %b want %b", k, dec, e.dec); end
      @(posedge clk);
      #1;
      checks++; if (cnt_o[31:0] !== cnt_exp[k]) begin errors++; $display("FAIL basic_cnt[%0d]: got %0d want %0d", k, cnt_o[31:0], cnt_exp[k]); end
    end
    valid = 1'b0;
  endtask

  task automatic test_nesting();
    wr(3'd0, 3'b111, 32'h180, 32'h120, 32'd2);
    wr(3'd1, 3'b111, 32'h140, 32'h120, 32'd5);
    exp_q.push_back('{1'b1, 32'h180, 4'b0001});
    @(negedge clk);
    pc = 32'h120; valid = 1'b1;
    #1 e = exp_q.pop_front();
    checks++; if (jump !== e.jump) begin errors++; $display("FAIL nest_jump: got %b want %b", jump, e.jump); end
    checks++; if (target !== e.target) begin errors++; $display("FAIL nest_target: got %h want %h", target, e.target); end
    checks++; if (dec !== e.dec) begin errors++; $display("FAIL nest_dec: got %b want %b", dec, e.dec); end
    @(posedge clk);
    #1 valid = 1'b0;
    checks++; if (cnt_o[63:0] !== {32'd5, 32'd1}) begin errors++; $display("FAIL nest_cnt: got %h want %h", cnt_o[63:0], {32'd5, 32'd1}); end
    // Inner loop disabled: outer loop is now selected
    wr(3'd0, 3'b100, 32'h0, 32'h0, 32'd0);
    exp_q.push_back('{1'b1, 32'h140, 4'b0010});
    @(negedge clk);
    valid = 1'b1;
    #1 e = exp_q.pop_front();
    checks++; if (jump !== e.jump) begin errors++; $display("FAIL outer_jump: got %b want %b", jump, e.jump); end
    checks++; if (target !== e.target) begin errors++; $display("FAIL outer_target: got %h want %h", target, e.target); end
    checks++; if (dec !== e.dec) begin errors++; $display("FAIL outer_dec: got %b want %b", dec, e.dec); end
    @(posedge clk);
    #1 valid = 1'b0;
    checks++; if (cnt_o[63:0] !== {32'd4, 32'd0}) begin errors++; $display("FAIL outer_cnt: got %h want %h", cnt_o[63:0], {32'd4, 32'd0}); end
  endtask

  task automatic test_write_priority();
    wr(3'd0, 3'b100, 32'h0, 32'h0, 32'd2);
    exp_q.push_back('{1'b1, 32'h180, 4'b0001});  // old start still used this cycle
    @(negedge clk);
    regid = 3'd0; we = 3'b101; start_data = 32'h1A0; cnt_data = 32'd7;
    pc = 32'h120; valid = 1'b1;
    #1 e = exp_q.pop_front();
    checks++; if (jump !== e.jump) begin errors++; $display("FAIL wp_jump: got %b want %b", jump, e.jump); end
    checks++; if (target !== e.target) begin errors++; $display("FAIL wp_target: got %h want %h", target, e.target); end
    checks++; if (dec !== e.dec) begin errors++; $display("FAIL wp_dec: got %b want %b", dec, e.dec); end
    @(posedge clk);
    #1 we = 3'b000; valid = 1'b0;
    checks++; if (cnt_o[31:0] !== 32'd7) begin errors++; $display("FAIL wp_cnt: got %0d want 7", cnt_o[31:0]); end
    checks++; if (start_o[31:0] !== 32'h1A0) begin errors++; $display("FAIL wp_start: got %h want 1a0", start_o[31:0]); end
  endtask

  task automatic test_invalid_and_oob();
    logic [N*32-1:0] e_start, e_end, e_cnt;
    wr(3'd0, 3'b100, 32'h0, 32'h0, 32'd4);
    exp_q.push_back('{1'b0, 32'h0, 4'b0000});
    @(negedge clk);
    pc = 32'h120; valid = 1'b0;
    #1 e = exp_q.pop_front();
    checks++; if (jump !== e.jump) begin errors++; $display("FAIL inv_jump: got %b want %b", jump, e.jump); end
    checks++; if (target !== e.target) begin errors++; $display("FAIL inv_target: got %h want %h", target, e.target); end
    checks++; if (dec !== e.dec) begin errors++; $display("FAIL inv_dec: got %b want %b", dec, e.dec); end
    @(posedge clk);
    #1;
    checks++; if (cnt_o[31:0] !== 32'd4) begin errors++; $display("FAIL inv_cnt: got %0d want 4", cnt_o[31:0]); end
    wr(3'd5, 3'b111, 32'hDEAD_0000, 32'hBEEF_0000, 32'd99);
    @(negedge clk);
    e_start = {32'h0, 32'h0, 32'h140, 32'h1A0};
    e_end   = {32'h0, 32'h0, 32'h120, 32'h120};
    e_cnt   = {32'h0, 32'h0, 32'd4,   32'd4};
    checks++; if (start_o !== e_start) begin errors++; $display("FAIL oob_start: got %h want %h", start_o, e_start); end
    checks++; if (end_o !== e_end) begin errors++; $display("FAIL oob_end: got %h want %h", end_o, e_end); end
    checks++; if (cnt_o !== e_cnt) begin errors++; $display("FAIL oob_cnt: got %h want %h", cnt_o, e_cnt); end
  endtask

  task automatic test_reset_mid_loop();
    @(negedge clk);
    pc = 32'h120; valid = 1'b1;
    #1;
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL mid_jump_pre: got %b want 1", jump); end
    rst_n = 1'b0;
    #1;
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL mid_jump_rst: got %b want 0", jump); end
    checks++; if (cnt_o !== '0) begin errors++; $display("FAIL mid_cnt_rst: got %h want 0", cnt_o); end
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef CV32E40P_HWLP_NEST_CHECK_EN
  task automatic test_nest_check();
    wr(3'd0, 3'b110, 32'h0, 32'h200, 32'd2);
    @(negedge clk);
    checks++; if (nest_err !== 1'b0) begin errors++; $display("FAIL nchk_init: got %b want 0", nest_err); end
    wr(3'd1, 3'b110, 32'h0, 32'h100, 32'd3);
    @(negedge clk);
    checks++; if (nest_err !== 1'b1) begin errors++; $display("FAIL nchk_set: got %b want 1", nest_err); end
    wr(3'd1, 3'b110, 32'h0, 32'h300, 32'd3);
    @(negedge clk);
    checks++; if (nest_err !== 1'b0) begin errors++; $display("FAIL nchk_clr: got %b want 0", nest_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_loop();
    test_nesting();
    test_write_priority();
    test_invalid_and_oob();
    test_reset_mid_loop();
`ifdef CV32E40P_HWLP_NEST_CHECK_EN
    test_nest_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
